// File: rtl/core_pkg.sv
// Shared decode constants for the RV32IM core: opcodes, ALU control codes,
// jump codes and bit positions inside the ID/EX control bundle.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // The 4-bit code is full, so DIVU/REMU share the DIV/REM codes.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_MUL    = 4'd10,
    ALU_MULH   = 4'd11,
    ALU_MULHSU = 4'd12,
    ALU_MULHU  = 4'd13,
    ALU_DIV    = 4'd14,
    ALU_REM    = 4'd15
  } alu_op_e;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam int CTRL_BRANCH     = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_JUMP_MSB   = 2;
  localparam int CTRL_JUMP_LSB   = 1;
  localparam int CTRL_ILLEGAL    = 0;

  function automatic alu_op_e aluBase(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e aluMul(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIV;
      default: return ALU_REM;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// x0 hard-wired to zero, optional same-cycle write-back forwarding.
module regfile
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1,
  parameter int RA_W      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] i_rs1_addr,
  input  logic [RA_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  function automatic logic [XLEN-1:0] readPort(input logic [RA_W-1:0] addr);
    if (addr == '0) return '0;
    if ((WB_BYPASS != 0) && i_we && (i_wr_addr == addr)) return i_wr_data;
    return r_regs[addr];
  endfunction

  assign o_rs1_data = readPort(i_rs1_addr);
  assign o_rs2_data = readPort(i_rs2_addr);

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: decodes one instruction per handshake, reads the register
// file and holds the result in the ID/EX register with load-use stall and flush.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int M_EXT     = 1,
  parameter int WB_BYPASS = 1,
  parameter int RA_W      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic            i_wb_we,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_ex_mem_read,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_rs1_data,
  output logic [XLEN-1:0] o_out_rs2_data,
  output logic [XLEN-1:0] o_out_imm,
  output logic [RA_W-1:0] o_out_rd,
  output logic [3:0]      o_out_alu_ctrl,
  output logic [8:0]      o_out_ctrl
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [RA_W-1:0] w_rs1_addr, w_rs2_addr;
  logic            w_rs1_used, w_rs2_used, w_legal, w_hazard, w_in_ready;
  logic [8:0]      w_dec_ctrl, w_ctrl;
  alu_op_e         w_dec_alu;
  logic [3:0]      w_alu;
  logic [31:0]     w_imm32;
  logic [RA_W-1:0] w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  assign w_opcode   = i_in_instr[6:0];
  assign w_funct3   = i_in_instr[14:12];
  assign w_funct7   = i_in_instr[31:25];
  assign w_rs1_addr = RA_W'(i_in_instr[19:15]);
  assign w_rs2_addr = RA_W'(i_in_instr[24:20]);

  always_comb begin
    w_dec_ctrl = '0;
    w_dec_alu  = ALU_ADD;
    w_imm32    = '0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_legal    = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        if (w_funct7 == 7'b0000000)                             w_dec_alu = aluBase(w_funct3);
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) w_dec_alu = ALU_SUB;
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) w_dec_alu = ALU_SRA;
        else if (w_funct7 == 7'b0000001 && M_EXT != 0)         w_dec_alu = aluMul(w_funct3);
        else                                                    w_legal   = 1'b0;
      end
      OPC_OP_IMM: begin
        w_rs1_used = 1'b1;
        w_dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
        if (w_funct3 == 3'b001) begin
          w_dec_alu = ALU_SLL;
          w_legal   = (w_funct7 == 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          if (w_funct7 == 7'b0000000)      w_dec_alu = ALU_SRL;
          else if (w_funct7 == 7'b0100000) w_dec_alu = ALU_SRA;
          else                             w_legal   = 1'b0;
        end else begin
          w_dec_alu = aluBase(w_funct3);
        end
      end
      OPC_LOAD: begin
        w_rs1_used = 1'b1;
        w_dec_ctrl[CTRL_MEM_READ]   = 1'b1;
        w_dec_ctrl[CTRL_MEM_TO_REG] = 1'b1;
        w_dec_ctrl[CTRL_ALU_SRC]    = 1'b1;
        w_dec_ctrl[CTRL_REG_WRITE]  = 1'b1;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
        w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
      end
      OPC_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec_ctrl[CTRL_MEM_WRITE] = 1'b1;
        w_dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
        w_legal = (w_funct3 < 3'd3);
      end
      OPC_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_dec_ctrl[CTRL_BRANCH] = 1'b1;
        w_imm32 = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                   i_in_instr[30:25], i_in_instr[11:8], 1'b0};
        case (w_funct3[2:1])
          2'b00:   w_dec_alu = ALU_SUB;
          2'b10:   w_dec_alu = ALU_SLT;
          2'b11:   w_dec_alu = ALU_SLTU;
          default: w_legal   = 1'b0;
        endcase
      end
      OPC_JAL: begin
        w_dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_dec_ctrl[CTRL_JUMP_MSB:CTRL_JUMP_LSB] = JMP_JAL;
        w_imm32 = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                   i_in_instr[20], i_in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_rs1_used = 1'b1;
        w_dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_dec_ctrl[CTRL_JUMP_MSB:CTRL_JUMP_LSB] = JMP_JALR;
        w_imm32 = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
        w_legal = (w_funct3 == 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        w_dec_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_dec_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_imm32 = {i_in_instr[31:12], 12'b0};
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal instructions still travel downstream, but with every side effect stripped.
  assign w_ctrl = w_legal ? w_dec_ctrl : (9'd1 << CTRL_ILLEGAL);
  assign w_alu  = w_legal ? w_dec_alu : ALU_ADD;
  assign w_rd   = w_ctrl[CTRL_REG_WRITE] ? RA_W'(i_in_instr[11:7]) : '0;

  regfile #(
    .XLEN      (XLEN),
    .NUM_REGS  (NUM_REGS),
    .WB_BYPASS (WB_BYPASS),
    .RA_W      (RA_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (w_rs1_used ? w_rs1_addr : '0),
    .i_rs2_addr (w_rs2_used ? w_rs2_addr : '0),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (i_wb_we),
    .i_wr_addr  (i_wb_rd),
    .i_wr_data  (i_wb_data)
  );

  assign w_hazard = i_ex_mem_read && (i_ex_rd != '0) &&
                    ((w_rs1_used && (i_ex_rd == w_rs1_addr)) ||
                     (w_rs2_used && (i_ex_rd == w_rs2_addr)));
  assign w_in_ready = rst_n && (!o_out_valid || i_out_ready) && !w_hazard && !i_flush;
  assign o_in_ready = w_in_ready;

  // Flush beats everything; otherwise the register loads, bubbles, or holds while EX stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid    <= 1'b0;
      o_out_pc       <= '0;
      o_out_rs1_data <= '0;
      o_out_rs2_data <= '0;
      o_out_imm      <= '0;
      o_out_rd       <= '0;
      o_out_alu_ctrl <= '0;
      o_out_ctrl     <= '0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (!o_out_valid || i_out_ready) begin
      if (i_in_valid && w_in_ready) begin
        o_out_valid    <= 1'b1;
        o_out_pc       <= i_in_pc;
        o_out_rs1_data <= w_rs1_data;
        o_out_rs2_data <= w_rs2_data;
        o_out_imm      <= XLEN'($signed(w_imm32));
        o_out_rd       <= w_rd;
        o_out_alu_ctrl <= w_alu;
        o_out_ctrl     <= w_ctrl;
      end else begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a transaction-level model of the stage
// checked every cycle, plus directed vectors with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, wb_we = 1'b0, ex_mem_read = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0, ex_rd = '0, out_rd;
  logic [31:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [3:0]  out_alu;
  logic [8:0]  out_ctrl;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_pc, n_rs1, n_rs2, n_imm;
  logic [4:0]  n_rd;
  logic [3:0]  n_alu;
  logic [8:0]  n_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NUM_REGS(32), .M_EXT(1), .WB_BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .i_wb_we(wb_we), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_pc(out_pc),
    .o_out_rs1_data(out_rs1), .o_out_rs2_data(out_rs2), .o_out_imm(out_imm),
    .o_out_rd(out_rd), .o_out_alu_ctrl(out_alu), .o_out_ctrl(out_ctrl)
  );

  decode_stage #(.XLEN(32), .NUM_REGS(32), .M_EXT(0), .WB_BYPASS(1)) dut_nom (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(n_in_ready),
    .i_in_instr(in_instr), .i_in_pc(in_pc), .i_wb_we(wb_we), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd), .i_flush(flush),
    .o_out_valid(n_out_valid), .i_out_ready(out_ready), .o_out_pc(n_pc),
    .o_out_rs1_data(n_rs1), .o_out_rs2_data(n_rs2), .o_out_imm(n_imm),
    .o_out_rd(n_rd), .o_out_alu_ctrl(n_alu), .o_out_ctrl(n_ctrl)
  );

  typedef struct packed {
    logic [3:0]  alu;
    logic [8:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        use1;
    logic        use2;
  } dec_t;

  // Reference decode, written as an instruction-class table rather than a datapath.
  function automatic dec_t refDecode(input logic [31:0] ins);
    dec_t d;
    logic ok, br, mr, m2r, mw, src, rw;
    logic [1:0] jmp;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] baseTbl [8];
    baseTbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '0;
    ok = 1'b1; br = 0; mr = 0; m2r = 0; mw = 0; src = 0; rw = 0; jmp = 2'b00;
    case (ins[6:0])
      7'h33: begin
        d.use1 = 1; d.use2 = 1; rw = 1;
        if (f7 == 7'h00) d.alu = baseTbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd7;
        else if (f7 == 7'h01) d.alu = (f3 < 4) ? 4'd10 + 4'(f3) : ((f3 < 6) ? 4'd14 : 4'd15);
        else ok = 0;
      end
      7'h13: begin
        d.use1 = 1; rw = 1; src = 1; d.imm = 32'($signed(ins[31:20]));
        d.alu = baseTbl[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd7;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 0;
      end
      7'h03: begin
        d.use1 = 1; mr = 1; m2r = 1; src = 1; rw = 1; d.imm = 32'($signed(ins[31:20]));
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        d.use1 = 1; d.use2 = 1; mw = 1; src = 1;
        d.imm = 32'($signed({ins[31:25], ins[11:7]}));
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        d.use1 = 1; d.use2 = 1; br = 1;
        d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ok = !(f3 == 2 || f3 == 3);
        d.alu = (f3 < 2) ? 4'd1 : ((f3 < 6) ? 4'd8 : 4'd9);
      end
      7'h6F: begin
        rw = 1; jmp = 2'b01;
        d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        d.use1 = 1; rw = 1; src = 1; jmp = 2'b10; d.imm = 32'($signed(ins[31:20]));
        ok = (f3 == 0);
      end
      7'h37, 7'h17: begin
        rw = 1; src = 1; d.imm = ins & 32'hFFFF_F000;
      end
      default: ok = 0;
    endcase
    if (ok) begin
      d.ctrl = {br, mr, m2r, mw, src, rw, jmp, 1'b0};
      d.rd   = rw ? ins[11:7] : 5'd0;
    end else begin
      d.ctrl = 9'h001;
      d.alu  = 4'd0;
      d.rd   = 5'd0;
    end
    return d;
  endfunction

  logic [31:0] mRegs [32];
  logic        mValid = 1'b0;
  logic [31:0] mPc, mRs1, mRs2, mImm;
  logic [4:0]  mRd;
  logic [3:0]  mAlu;
  logic [8:0]  mCtrl;

  function automatic logic [31:0] readReg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return mRegs[idx];
  endfunction

  function automatic logic modelReady();
    dec_t d;
    logic hz;
    d = refDecode(in_instr);
    hz = ex_mem_read && ex_rd != 0 &&
         ((d.use1 && ex_rd == in_instr[19:15]) || (d.use2 && ex_rd == in_instr[24:20]));
    return rst_n && (!mValid || out_ready) && !hz && !flush;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mValid = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mImm = 0; mRd = 0; mAlu = 0; mCtrl = 0;
      end else begin
        dec_t d;
        logic rdy;
        d = refDecode(in_instr);
        rdy = modelReady();
        if (flush) mValid = 0;
        else if (!mValid || out_ready) begin
          if (in_valid && rdy) begin
            mValid = 1; mPc = in_pc; mImm = d.imm; mRd = d.rd; mAlu = d.alu; mCtrl = d.ctrl;
            mRs1 = d.use1 ? readReg(in_instr[19:15]) : 32'd0;
            mRs2 = d.use2 ? readReg(in_instr[24:20]) : 32'd0;
          end else mValid = 0;
        end
        if (wb_we && wb_rd != 0) mRegs[wb_rd] = wb_data;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Every cycle out of reset, the DUT must agree with the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("model_in_ready", 32'(in_ready), 32'(modelReady()));
        checkOutput("model_out_valid", 32'(out_valid), 32'(mValid));
        if (mValid) begin
          checkOutput("model_pc", out_pc, mPc);
          checkOutput("model_rs1", out_rs1, mRs1);
          checkOutput("model_rs2", out_rs2, mRs2);
          checkOutput("model_imm", out_imm, mImm);
          checkOutput("model_rd", 32'(out_rd), 32'(mRd));
          checkOutput("model_alu", 32'(out_alu), 32'(mAlu));
          checkOutput("model_ctrl", 32'(out_ctrl), 32'(mCtrl));
        end
      end
    end
  end

  logic [31:0] tblInstr [10] = '{32'h0020A423, 32'hFE208EE3, 32'h123452B7, 32'h008000EF,
                                 32'h00412183, 32'h00008067, 32'h4033D313, 32'h40730633,
                                 32'h00002063, 32'hFFFFFFFF};
  logic [31:0] tblImm [10]   = '{32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h8, 32'h4, 32'h0,
                                 32'h403, 32'h0, 32'h0, 32'h0};
  logic [31:0] tblCtrl [10]  = '{32'h030, 32'h100, 32'h018, 32'h00A, 32'h0D8, 32'h01C,
                                 32'h018, 32'h008, 32'h001, 32'h001};
  logic [31:0] wbRegVal [4]  = '{32'h11, 32'h22, 32'h7, 32'h9};
  logic [4:0]  wbRegIdx [4]  = '{5'd2, 5'd3, 5'd6, 5'd7};

  initial begin
    repeat (2) applyStimulus();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_ctrl", 32'(out_ctrl), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wb_we = 1; wb_rd = wbRegIdx[i]; wb_data = wbRegVal[i];
      applyStimulus();
    end
    wb_we = 0;

    // addi x1,x0,5
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    applyStimulus();
    in_valid = 0;
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_imm", out_imm, 32'd5);
    checkOutput("addi_rd", 32'(out_rd), 32'd1);
    checkOutput("addi_ctrl", 32'(out_ctrl), 32'h018);
    checkOutput("addi_pc", out_pc, 32'h100);

    // add x4,x3,x2 behind a load writing x3
    ex_mem_read = 1; ex_rd = 5'd3; in_valid = 1; in_instr = 32'h00218233; in_pc = 32'h104;
    #1 checkOutput("hazard_in_ready", 32'(in_ready), 32'd0);
    applyStimulus();
    checkOutput("hazard_bubble", 32'(out_valid), 32'd0);
    ex_mem_read = 0;
    #1 checkOutput("hazard_clear_ready", 32'(in_ready), 32'd1);
    applyStimulus();
    in_valid = 0;
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_rs1", out_rs1, 32'h22);
    checkOutput("add_rs2", out_rs2, 32'h11);
    checkOutput("add_ctrl", 32'(out_ctrl), 32'h008);

    // ori x5,x0,0xF0 then stall with addi waiting behind it
    in_valid = 1; in_instr = 32'h0F006293; in_pc = 32'h108;
    applyStimulus();
    out_ready = 0; in_instr = 32'h00500093; in_pc = 32'h10C;
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_imm", out_imm, 32'hF0);
      checkOutput("stall_rd", 32'(out_rd), 32'd5);
      checkOutput("stall_alu", 32'(out_alu), 32'd3);
      checkOutput("stall_pc", out_pc, 32'h108);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    applyStimulus();
    checkOutput("release_pc", out_pc, 32'h10C);
    checkOutput("release_rd", 32'(out_rd), 32'd1);

    // WB bypass and x0 protection
    in_instr = 32'h002084B3; wb_we = 1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("bypass_rs2", out_rs2, 32'hDEADBEEF);
    in_instr = 32'h00000533; wb_rd = 5'd0; wb_data = 32'h55;
    applyStimulus();
    wb_we = 0;
    checkOutput("x0_bypass_rs1", out_rs1, 32'd0);
    applyStimulus();
    checkOutput("x0_kept_rs2", out_rs2, 32'd0);
    in_instr = 32'h000105B3;
    applyStimulus();
    checkOutput("wb_written_rs1", out_rs1, 32'hDEADBEEF);

    // mul x5,x6,x7 on both M_EXT settings
    in_instr = 32'h027302B3;
    applyStimulus();
    checkOutput("mul_alu", 32'(out_alu), 32'd10);
    checkOutput("mul_ctrl", 32'(out_ctrl), 32'h008);
    checkOutput("mul_rs1", out_rs1, 32'h7);
    checkOutput("mul_rs2", out_rs2, 32'h9);
    checkOutput("nom_mul_valid", 32'(n_out_valid), 32'd1);
    checkOutput("nom_mul_ctrl", 32'(n_ctrl), 32'h001);
    checkOutput("nom_mul_alu", 32'(n_alu), 32'd0);

    for (int i = 0; i < 10; i++) begin
      in_instr = tblInstr[i]; in_pc = 32'h200 + 32'(i * 4);
      applyStimulus();
      checkOutput("tbl_imm", out_imm, tblImm[i]);
      checkOutput("tbl_ctrl", 32'(out_ctrl), tblCtrl[i]);
    end

    // flush kills a held instruction even while EX stalls
    out_ready = 0; in_instr = 32'h00500093;
    flush = 1;
    #1 checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    applyStimulus();
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    flush = 0; out_ready = 1;
    ex_mem_read = 1; ex_rd = 5'd3; in_instr = 32'h00218233; flush = 1;
    applyStimulus();
    checkOutput("flush_hazard_valid", 32'(out_valid), 32'd0);
    flush = 0; ex_mem_read = 0;
    applyStimulus();
    checkOutput("after_flush_rs1", out_rs1, 32'h22);

    // loosely constrained traffic, judged by the model alone
    for (int c = 0; c < 80; c++) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      in_instr    = tblInstr[$urandom_range(0, 9)];
      in_pc       = $urandom;
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      wb_we       = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      applyStimulus();
    end
    wb_we = 0; ex_mem_read = 0; flush = 0; out_ready = 0;

    // reset during a stall drops everything immediately
    in_valid = 1; in_instr = 32'h00218233;
    applyStimulus();
    applyStimulus();
    #2 rst_n = 0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_rs1", out_rs1, 32'd0);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    checkOutput("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    applyStimulus();
    rst_n = 1; out_ready = 1;
    applyStimulus();
    checkOutput("rst_regs_cleared", out_rs1, 32'd0);
    in_valid = 0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
